// File: rtl/iiitb_usr_deser.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_usr_deser
// Description : Serial-in / parallel-out receiver. Collects WIDTH serial bits
//               (MSB-first or LSB-first, selected per frame) into a shift
//               register. Each completed word goes to a held output register
//               with a valid/ack handshake. A sticky flag records any word
//               that completes while the output register still holds an
//               unacknowledged word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      word width in bits (must be >= 2)
//   CNT_W      bit-counter width; 2**CNT_W must exceed WIDTH
// Ports
//   clock      in   1      system clock, all state on the rising edge
//   clear      in   1      asynchronous active-high reset
//   ser_in     in   1      serial data bit
//   ser_valid  in   1      ser_in is taken on this edge when high
//   dir        in   1      0 = MSB-first, 1 = LSB-first; latched at frame start
//   flush      in   1      synchronous; discards the partial frame
//   data_ack   in   1      consumer accepts data_out on this edge
//   data_out   out  WIDTH  last delivered word
//   data_valid out  1      data_out holds an unacknowledged word
//   busy       out  1      partial frame in progress
//   bit_cnt    out  CNT_W  bits received in the current frame
//   overrun    out  1      sticky: a completed word was dropped
// ============================================================================
module iiitb_usr_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             dir,
  input  logic             flush,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]       c_IDLE     = 1'b0;
  localparam logic [0:0]       c_RECV     = 1'b1;
  // Counter value seen before the edge that carries the final bit of a word.
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             w_busy;

  // --------------------------------------------------------------------------
  // Datapath decode
  // --------------------------------------------------------------------------
  logic             w_idle;
  logic             w_accept;
  logic             w_dir_eff;
  logic             w_last;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;
  logic             w_release;
  logic [WIDTH-1:0] w_sreg_shift;

  assign w_idle   = (r_state == c_IDLE);

  // flush wins over a valid bit on the same edge, so that bit is never taken.
  assign w_accept = ser_valid & ~flush;

  // The first bit of a frame must already follow the new direction, so in
  // IDLE the live dir input is used; afterwards the latched copy rules and
  // mid-frame changes of dir have no effect.
  assign w_dir_eff = w_idle ? dir : r_dir;

  assign w_sreg_shift = w_dir_eff ? {ser_in, r_sreg[WIDTH-1:1]}
                                  : {r_sreg[WIDTH-2:0], ser_in};

  // The final bit can only arrive in RECV because WIDTH >= 2.
  assign w_last     = (r_state == c_RECV) && (r_cnt == c_LAST_CNT);
  assign w_complete = w_accept & w_last;

  // A completing word is delivered when the output slot is free or is being
  // freed on this very edge; otherwise it is dropped and flagged.
  assign w_load    = w_complete & (~r_valid | data_ack);
  assign w_drop    = w_complete &   r_valid & ~data_ack;
  assign w_release = ~w_complete & r_valid & data_ack;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_RECV;
        end
      end
      c_RECV: begin
        if (flush || w_complete) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      c_IDLE:  w_busy = 1'b0;
      c_RECV:  w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame collection: shift register, bit counter, latched direction
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_sreg <= '0;
      r_cnt  <= c_CNT_ZERO;
      r_dir  <= 1'b0;
    end else begin
      if (flush) begin
        r_sreg <= '0;
        r_cnt  <= c_CNT_ZERO;
      end else if (ser_valid) begin
        r_sreg <= w_sreg_shift;
        // Wrap to zero on the completing bit so the next frame can start on
        // the very next edge without an idle cycle.
        if (w_last) begin
          r_cnt <= c_CNT_ZERO;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
        if (w_idle) begin
          r_dir <= dir;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register, handshake and overrun flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        // Includes the bit arriving on this edge: zero-cycle delivery.
        r_data  <= w_sreg_shift;
        r_valid <= 1'b1;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = w_busy;
  assign bit_cnt    = r_cnt;
  assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_usr_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiitb_usr_deser
// Description : Self-checking bench for iiitb_usr_deser. Directed frames push
//               their expected words into a queue; a monitor pops and compares
//               whenever the DUT presents a new word. Status outputs are
//               checked directly against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iiitb_usr_deser;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clock;
  logic             clear;
  logic             ser_in;
  logic             ser_valid;
  logic             dir;
  logic             flush;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  iiitb_usr_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .clear      (clear),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .dir        (dir),
    .flush      (flush),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: a new word is presented when data_valid rises or data_out
  // changes while data_valid stays high.
  logic             prev_v = 1'b0;
  logic [WIDTH-1:0] prev_d = '0;
  logic [WIDTH-1:0] exp_w;

  always @(negedge clock) begin
    if (clear) begin
      prev_v = 1'b0;
      prev_d = '0;
    end else begin
      if (data_valid && (!prev_v || data_out != prev_d)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got %0h expected none (t=%0t)", data_out, $time);
        end else begin
          exp_w = exp_q.pop_front();
          chk("scoreboard_word", 32'(data_out), 32'(exp_w));
        end
      end
      prev_v = data_valid;
      prev_d = data_out;
    end
  end

  // One clock edge of stimulus; inputs are applied at a falling edge and the
  // task returns at the next falling edge, where outputs may be checked.
  task automatic drive(input logic b, input logic v, input logic a, input logic f);
    ser_in    = b;
    ser_valid = v;
    data_ack  = a;
    flush     = f;
    @(negedge clock);
    ser_valid = 1'b0;
    data_ack  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic lsb, input logic ack_last);
    for (int i = 0; i < 8; i++) begin
      drive(lsb ? w[i] : w[7-i], 1'b1, ack_last && (i == 7), 1'b0);
    end
  endtask

  task automatic pulse_clear();
    #1 clear = 1'b1;
    #2 clear = 1'b0;
    @(negedge clock);
  endtask

  logic [7:0] bits2;

  initial begin
    clear = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; dir = 1'b0;
    flush = 1'b0; data_ack = 1'b0;
    #6 clear = 1'b0;
    @(negedge clock);

    // ---- Reset state ----
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_valid",    32'(data_valid), 32'h0);
    chk("rst_busy",     32'(busy), 32'h0);
    chk("rst_bit_cnt",  32'(bit_cnt), 32'h0);
    chk("rst_overrun",  32'(overrun), 32'h0);

    // ---- 1: MSB-first 1,0,1,0,1,0,1,1 -> AB ----
    dir = 1'b0;
    exp_q.push_back(8'hAB);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_busy_first", 32'(busy), 32'h1);
    chk("t1_cnt_first",  32'(bit_cnt), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_valid_before_last", 32'(data_valid), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_data", 32'(data_out), 32'hAB);
    chk("t1_valid", 32'(data_valid), 32'h1);
    chk("t1_busy_done", 32'(busy), 32'h0);
    chk("t1_cnt_done", 32'(bit_cnt), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_acked", 32'(data_valid), 32'h0);
    chk("t1_data_held", 32'(data_out), 32'hAB);

    // ---- 2: LSB-first 1,1,0,1,0,1,0,1 with dir toggled mid-frame -> AB ----
    dir = 1'b1;
    exp_q.push_back(8'hAB);
    bits2 = 8'b1101_0101;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) dir = 1'b0;
      drive(bits2[7-i], 1'b1, 1'b0, 1'b0);
    end
    chk("t2_data", 32'(data_out), 32'hAB);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_acked", 32'(data_valid), 32'h0);

    // ---- 3: gapped all-ones frame -> FF ----
    dir = 1'b0;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_cnt_accept", 32'(bit_cnt), 32'((i + 1) % 8));
      if (i < 7) chk("t3_no_valid", 32'(data_valid), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_cnt_gap", 32'(bit_cnt), 32'((i + 1) % 8));
    end
    chk("t3_data", 32'(data_out), 32'hFF);
    chk("t3_valid", 32'(data_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // ---- 4a: back-to-back without ack -> second word dropped ----
    pulse_clear();
    chk("t4_clear_data", 32'(data_out), 32'h0);
    exp_q.push_back(8'hF0);
    send_word(8'hF0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0);
    chk("t4a_data", 32'(data_out), 32'hF0);
    chk("t4a_overrun", 32'(overrun), 32'h1);
    chk("t4a_valid", 32'(data_valid), 32'h1);

    // ---- 4b: ack on the second word's last edge -> delivered ----
    pulse_clear();
    chk("t4b_clear_overrun", 32'(overrun), 32'h0);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send_word(8'hF0, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b1);
    chk("t4b_data", 32'(data_out), 32'h0F);
    chk("t4b_valid", 32'(data_valid), 32'h1);
    chk("t4b_overrun", 32'(overrun), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // ---- 5a: flush with a 6th valid bit discards the partial frame ----
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt_partial", 32'(bit_cnt), 32'h5);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_flush_cnt", 32'(bit_cnt), 32'h0);
    chk("t5_flush_busy", 32'(busy), 32'h0);
    chk("t5_flush_data", 32'(data_out), 32'h0F);
    exp_q.push_back(8'h3C);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("t5_data", 32'(data_out), 32'h3C);

    // ---- 5b: asynchronous clear mid-frame, between edges ----
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5b_busy_pre", 32'(busy), 32'h1);
    #2 clear = 1'b1;
    #1;
    chk("t5b_data", 32'(data_out), 32'h0);
    chk("t5b_valid", 32'(data_valid), 32'h0);
    chk("t5b_busy", 32'(busy), 32'h0);
    chk("t5b_cnt", 32'(bit_cnt), 32'h0);
    chk("t5b_overrun", 32'(overrun), 32'h0);
    #1 clear = 1'b0;
    @(negedge clock);
    @(negedge clock);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
